// File: rtl/food_gen.sv
// food_gen: picks a free food cell from LFSR samples, with a linear
// scan fallback so placement always terminates.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   rand_num[8:0]      LFSR sample: x = [4:0], y = [8:5]
//   req                1-cycle pulse: place new food
//   head_x, head_y     snake head, rejected directly
//   chk_en/x/y         occupancy probe to the snake body store
//   chk_hit            registered probe result, valid the cycle after chk_en
//   food_x, food_y     current food cell
//   food_valid         food_x/food_y hold a placed food
//   busy               search in progress
//   done               1-cycle pulse: new food accepted
//   grid_full          every cell occupied, no food placed
module food_gen #(
    parameter int GRID_W  = 30,
    parameter int GRID_H  = 15,
    parameter int MAX_TRY = 8,
    parameter int INIT_X  = 10,
    parameter int INIT_Y  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] rand_num,
    input  logic       req,
    input  logic [4:0] head_x,
    input  logic [3:0] head_y,
    output logic       chk_en,
    output logic [4:0] chk_x,
    output logic [3:0] chk_y,
    input  logic       chk_hit,
    output logic [4:0] food_x,
    output logic [3:0] food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       done,
    output logic       grid_full
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_PROBE  = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_SCAN   = 3'd4;

    localparam logic [5:0] GW       = 6'(GRID_W);
    localparam logic [4:0] GH       = 5'(GRID_H);
    localparam logic [4:0] X_LAST   = 5'(GRID_W - 1);
    localparam logic [3:0] Y_LAST   = 4'(GRID_H - 1);
    localparam logic [7:0] TRY_LAST = 8'(MAX_TRY);
    localparam logic [9:0] CELLS    = 10'(GRID_W * GRID_H);
    localparam logic [4:0] IX       = 5'(INIT_X);
    localparam logic [3:0] IY       = 4'(INIT_Y);

    logic [2:0] state;
    logic [7:0] try_cnt;
    logic [8:0] scan_cnt;
    logic [4:0] cand_x;
    logic [3:0] cand_y;
    logic       scan_mode;
    logic       scan_adv;

    logic [4:0] cx;
    logic [3:0] cy;
    logic       oor;
    logic [7:0] try_inc;
    logic       try_end;
    logic [9:0] scan_inc;
    logic       scan_end;
    logic       reject;
    logic [4:0] adv_x;
    logic [3:0] adv_y;
    logic [4:0] nxt_x;
    logic [3:0] nxt_y;

    assign cx = rand_num[4:0];
    assign cy = rand_num[8:5];

    assign oor = ({1'b0, cx} >= GW) ||
                 ({1'b0, cy} >= GH);

    assign try_inc = try_cnt + 8'd1;
    assign try_end = (try_inc == TRY_LAST);

    // 10-bit so a full 32x16 grid cannot alias to zero
    assign scan_inc = {1'b0, scan_cnt} + 10'd1;
    assign scan_end = (scan_inc == CELLS);

    assign reject = chk_hit ||
                    ((cand_x == head_x) &&
                     (cand_y == head_y));

    // raster-order successor of the current candidate
    always_comb begin
        adv_x = cand_x + 5'd1;
        adv_y = cand_y;
        if (cand_x == X_LAST) begin
            adv_x = 5'd0;
            if (cand_y == Y_LAST) begin
                adv_y = 4'd0;
            end else begin
                adv_y = cand_y + 4'd1;
            end
        end
    end

    // the out-of-range entry already parks cand at (0,0)
    assign nxt_x = scan_adv ? adv_x : cand_x;
    assign nxt_y = scan_adv ? adv_y : cand_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            try_cnt    <= 8'd0;
            scan_cnt   <= 9'd0;
            cand_x     <= 5'd0;
            cand_y     <= 4'd0;
            scan_mode  <= 1'b0;
            scan_adv   <= 1'b0;
            chk_en     <= 1'b0;
            chk_x      <= 5'd0;
            chk_y      <= 4'd0;
            food_x     <= IX;
            food_y     <= IY;
            food_valid <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            grid_full  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        state      <= S_SAMPLE;
                        busy       <= 1'b1;
                        food_valid <= 1'b0;
                        grid_full  <= 1'b0;
                        try_cnt    <= 8'd0;
                        scan_mode  <= 1'b0;
                    end
                end
                S_SAMPLE: begin
                    cand_x <= cx;
                    cand_y <= cy;
                    if (oor) begin
                        try_cnt <= try_inc;
                        if (try_end) begin
                            cand_x    <= 5'd0;
                            cand_y    <= 4'd0;
                            scan_mode <= 1'b1;
                            scan_adv  <= 1'b0;
                            scan_cnt  <= 9'd0;
                            state     <= S_SCAN;
                        end
                    end else begin
                        chk_x  <= cx;
                        chk_y  <= cy;
                        chk_en <= 1'b1;
                        state  <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    chk_en <= 1'b0;
                    state  <= S_CHECK;
                end
                S_CHECK: begin
                    if (!reject) begin
                        food_x     <= cand_x;
                        food_y     <= cand_y;
                        food_valid <= 1'b1;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else if (!scan_mode) begin
                        try_cnt <= try_inc;
                        if (try_end) begin
                            scan_mode <= 1'b1;
                            scan_adv  <= 1'b1;
                            scan_cnt  <= 9'd0;
                            state     <= S_SCAN;
                        end else begin
                            state <= S_SAMPLE;
                        end
                    end else begin
                        scan_cnt <= scan_inc[8:0];
                        if (scan_end) begin
                            grid_full <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            scan_adv <= 1'b1;
                            state    <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    cand_x <= nxt_x;
                    cand_y <= nxt_y;
                    chk_x  <= nxt_x;
                    chk_y  <= nxt_y;
                    chk_en <= 1'b1;
                    state  <= S_PROBE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_food_gen.sv
// tb_food_gen: directed checks of food_gen on the default 30x15 grid
// and on a 4x2 grid for the grid-full path.
module tb_food_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [8:0] rand_num = 9'd0;
    logic       req = 1'b0;
    logic [4:0] head_x = 5'd0;
    logic [3:0] head_y = 4'd0;
    logic       chk_en;
    logic [4:0] chk_x;
    logic [3:0] chk_y;
    logic       chk_hit = 1'b0;
    logic [4:0] food_x;
    logic [3:0] food_y;
    logic       food_valid;
    logic       busy;
    logic       done;
    logic       grid_full;

    logic [8:0] rand2 = 9'd0;
    logic       req2 = 1'b0;
    logic       chk_en2;
    logic [4:0] chk_x2;
    logic [3:0] chk_y2;
    logic       chk_hit2 = 1'b0;
    logic [4:0] food_x2;
    logic [3:0] food_y2;
    logic       food_valid2;
    logic       busy2;
    logic       done2;
    logic       grid_full2;

    logic [31:0] occ [0:15];
    logic [8:0]  rseq [0:63];
    int          rlen = 1;

    int         probe_n = 0;
    logic [4:0] probe_x = 5'd0;
    logic [3:0] probe_y = 4'd0;
    int         probe2_n = 0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    food_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rand_num   (rand_num),
        .req        (req),
        .head_x     (head_x),
        .head_y     (head_y),
        .chk_en     (chk_en),
        .chk_x      (chk_x),
        .chk_y      (chk_y),
        .chk_hit    (chk_hit),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .busy       (busy),
        .done       (done),
        .grid_full  (grid_full)
    );

    food_gen #(
        .GRID_W (4),
        .GRID_H (2),
        .INIT_X (1),
        .INIT_Y (1)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rand_num   (rand2),
        .req        (req2),
        .head_x     (5'd0),
        .head_y     (4'd0),
        .chk_en     (chk_en2),
        .chk_x      (chk_x2),
        .chk_y      (chk_y2),
        .chk_hit    (chk_hit2),
        .food_x     (food_x2),
        .food_y     (food_y2),
        .food_valid (food_valid2),
        .busy       (busy2),
        .done       (done2),
        .grid_full  (grid_full2)
    );

    // snake body store: registered occupancy lookup
    always @(posedge clk) begin
        chk_hit <= chk_en && occ[chk_y][chk_x];
        if (chk_en) begin
            probe_n <= probe_n + 1;
            probe_x <= chk_x;
            probe_y <= chk_y;
        end
        chk_hit2 <= chk_en2;
        if (chk_en2) begin
            probe2_n <= probe2_n + 1;
        end
    end

    task automatic expect_eq(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_occ();
        for (int i = 0; i < 16; i++) begin
            occ[i] = 32'd0;
        end
    endtask

    // pulse req, then feed rseq[c-1] ahead of edge c; lat = edge of done
    task automatic place(input int lim, output int lat);
        lat = -1;
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        for (int c = 1; c <= lim; c++) begin
            rand_num = rseq[(c - 1 < rlen) ? c - 1 : rlen - 1];
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int p0;
        int gf_lat;
        logic seen_done;

        clear_occ();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        expect_eq("rst_food_x", food_x, 10);
        expect_eq("rst_food_y", food_y, 7);
        expect_eq("rst_valid", food_valid, 1);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_done", done, 0);
        expect_eq("rst_gfull", grid_full, 0);
        expect_eq("rst_chk_en", chk_en, 0);

        // fast accept
        head_x = 5'd0;
        head_y = 4'd0;
        rseq[0] = 9'h0A5;
        rlen = 1;
        p0 = probe_n;
        place(20, lat);
        expect_eq("fast_lat", lat, 3);
        expect_eq("fast_x", food_x, 5);
        expect_eq("fast_y", food_y, 5);
        expect_eq("fast_valid", food_valid, 1);
        expect_eq("fast_busy", busy, 0);
        expect_eq("fast_probes", probe_n - p0, 1);
        expect_eq("fast_px", probe_x, 5);
        expect_eq("fast_py", probe_y, 5);
        @(posedge clk);
        #1;
        expect_eq("done_pulse", done, 0);
        expect_eq("chk_hold_en", chk_en, 0);
        expect_eq("chk_hold_x", chk_x, 5);

        // out of range, then occupied, then free
        occ[5][5] = 1'b1;
        rseq[0] = 9'h01F;
        rseq[1] = 9'h0A5;
        rseq[2] = 9'h0A5;
        rseq[3] = 9'h0A5;
        rseq[4] = 9'h043;
        rlen = 5;
        p0 = probe_n;
        place(30, lat);
        expect_eq("oor_lat", lat, 7);
        expect_eq("oor_x", food_x, 3);
        expect_eq("oor_y", food_y, 2);
        expect_eq("oor_probes", probe_n - p0, 2);
        clear_occ();

        // head collision
        head_x = 5'd4;
        head_y = 4'd4;
        rseq[0] = 9'h084;
        rseq[1] = 9'h084;
        rseq[2] = 9'h084;
        rseq[3] = 9'h066;
        rlen = 4;
        place(30, lat);
        expect_eq("head_lat", lat, 6);
        expect_eq("head_x", food_x, 6);
        expect_eq("head_y", food_y, 3);

        // 8 occupied random picks, last (29,14), scan wraps to (0,0)
        head_x = 5'd20;
        head_y = 4'd10;
        for (int i = 0; i < 7; i++) begin
            occ[1][i + 1] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                rseq[3 * i + k] = 9'(9'h020 + i + 1);
            end
        end
        occ[14][29] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rseq[21 + k] = 9'h1DD;
        end
        rlen = 24;
        p0 = probe_n;
        place(60, lat);
        expect_eq("scan_lat", lat, 27);
        expect_eq("scan_x", food_x, 0);
        expect_eq("scan_y", food_y, 0);
        expect_eq("scan_probes", probe_n - p0, 9);
        expect_eq("scan_py", probe_y, 0);
        clear_occ();

        // 8 out-of-range picks: scan starts at (0,0) unadvanced
        for (int i = 0; i < 8; i++) begin
            rseq[i] = (i % 2 == 0) ? 9'h1FF : 9'h1E0;
        end
        rlen = 8;
        p0 = probe_n;
        place(40, lat);
        expect_eq("oscan_lat", lat, 11);
        expect_eq("oscan_x", food_x, 0);
        expect_eq("oscan_y", food_y, 0);
        expect_eq("oscan_probes", probe_n - p0, 1);

        // 4x2 grid, every cell occupied
        p0 = probe2_n;
        gf_lat = -1;
        seen_done = 1'b0;
        @(negedge clk);
        req2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req2 = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            #1;
            if (done2) begin
                seen_done = 1'b1;
            end
            if (grid_full2) begin
                gf_lat = c;
                break;
            end
        end
        expect_eq("full_lat", gf_lat, 48);
        expect_eq("full_flag", grid_full2, 1);
        expect_eq("full_busy", busy2, 0);
        expect_eq("full_valid", food_valid2, 0);
        expect_eq("full_nodone", seen_done, 0);
        expect_eq("full_probes", probe2_n - p0, 16);

        // new req clears grid_full
        @(negedge clk);
        req2 = 1'b1;
        @(posedge clk);
        #1;
        expect_eq("req_clr_full", grid_full2, 0);
        expect_eq("req_busy", busy2, 1);
        @(negedge clk);
        req2 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        expect_eq("mid_busy", busy2, 1);

        // reset mid-scan
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_eq("ar_busy", busy2, 0);
        expect_eq("ar_valid", food_valid2, 1);
        expect_eq("ar_x", food_x2, 1);
        expect_eq("ar_y", food_y2, 1);
        expect_eq("ar_chk_en", chk_en2, 0);
        expect_eq("ar_chk_x", chk_x2, 0);
        expect_eq("ar_gfull", grid_full2, 0);
        expect_eq("ar_main_x", food_x, 10);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
